// File: rtl/prim_dom_pkg.sv
// Package for the DOM share generator.
// Purpose : shared state encoding and constants for prim_dom_share_gen and its splitter.
// Contents: dom_gen_st_e (controller states) and the number of random words per operation.
package prim_dom_pkg;

   // Three random words per operation: mask a, mask b, refresh z.
   localparam int unsigned NumRndWords = 3;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StGetA    = 3'd1,
      StGetB    = 3'd2,
      StGetZ    = 3'd3,
      StShare   = 3'd4,
      StPresent = 3'd5
   } dom_gen_st_e;

endpackage

// File: rtl/prim_dom_share_split.sv
// Registered single-operand splitter.
// Purpose : holds one plaintext operand until its mask arrives, then produces the two
//           Boolean shares (share0 = rnd, share1 = plain ^ rnd) and wipes the plaintext.
// Ports   : clk_i, rst_i (sync, active-high)
//           load_i    capture plain_i into the plaintext register
//           plain_i   unmasked operand
//           ack_i     consume rnd_i as the mask for this operand
//           rnd_i     random mask word
//           clear_i   wipe both share registers and the plaintext register
//           share0_o  mask share
//           share1_o  masked operand share
module prim_dom_share_split #(
   parameter int unsigned DW = 64
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          load_i,
   input  logic [DW-1:0] plain_i,
   input  logic          ack_i,
   input  logic [DW-1:0] rnd_i,
   input  logic          clear_i,
   output logic [DW-1:0] share0_o,
   output logic [DW-1:0] share1_o
);

   logic [DW-1:0] plain_q, plain_d;
   logic [DW-1:0] sh0_q, sh0_d;
   logic [DW-1:0] sh1_q, sh1_d;

   always_comb begin
      plain_d = plain_q;
      sh0_d   = sh0_q;
      sh1_d   = sh1_q;
      if (clear_i) begin
         plain_d = '0;
         sh0_d   = '0;
         sh1_d   = '0;
      end else if (ack_i) begin
         sh0_d   = rnd_i;
         sh1_d   = plain_q ^ rnd_i;
         // Plaintext must not outlive its mask.
         plain_d = '0;
      end else if (load_i) begin
         plain_d = plain_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         plain_q <= '0;
         sh0_q   <= '0;
         sh1_q   <= '0;
      end else begin
         plain_q <= plain_d;
         sh0_q   <= sh0_d;
         sh1_q   <= sh1_d;
      end
   end

   assign share0_o = sh0_q;
   assign share1_o = sh1_q;

endmodule

// File: rtl/prim_dom_share_gen.sv
// Masking front end for a 2-share DOM AND gate.
// Purpose : accepts two unmasked operands, fetches three random words (mask a, mask b,
//           refresh z), drives registered shares a0/a1, b0/b1 and c0 = c1 = z, holds them
//           for HoldCycles clocks, then raises out_valid_o until out_ready_i, after which
//           all shares are wiped.
// Ports   : clk_i, rst_i (sync, active-high)
//           in_valid_i / in_ready_o     operand handshake, a_i, b_i operands
//           rnd_req_o / rnd_ack_i       entropy handshake, one word rnd_i per ack
//           a0_o, a1_o, b0_o, b1_o      operand shares
//           c0_o, c1_o                  refresh randomness (identical)
//           out_valid_o / out_ready_i   share presentation handshake
module prim_dom_share_gen
   import prim_dom_pkg::*;
#(
   parameter int unsigned DW         = 64,
   parameter int unsigned HoldCycles = 2
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   input  logic [DW-1:0] a_i,
   input  logic [DW-1:0] b_i,
   output logic          rnd_req_o,
   input  logic          rnd_ack_i,
   input  logic [DW-1:0] rnd_i,
   output logic [DW-1:0] a0_o,
   output logic [DW-1:0] a1_o,
   output logic [DW-1:0] b0_o,
   output logic [DW-1:0] b1_o,
   output logic [DW-1:0] c0_o,
   output logic [DW-1:0] c1_o,
   output logic          out_valid_o,
   input  logic          out_ready_i
);

   localparam int unsigned CntW = $clog2(HoldCycles + 1);

   dom_gen_st_e   st_q, st_d;
   logic [CntW-1:0] hold_q, hold_d;
   logic [DW-1:0] z_q, z_d;

   logic load;
   logic ack_a;
   logic ack_b;
   logic wipe;

   always_comb begin
      st_d        = st_q;
      hold_d      = hold_q;
      z_d         = z_q;
      in_ready_o  = 1'b0;
      rnd_req_o   = 1'b0;
      out_valid_o = 1'b0;
      load        = 1'b0;
      ack_a       = 1'b0;
      ack_b       = 1'b0;
      wipe        = 1'b0;
      unique case (st_q)
         StIdle: begin
            in_ready_o = 1'b1;
            if (in_valid_i) begin
               load = 1'b1;
               st_d = StGetA;
            end
         end
         StGetA: begin
            rnd_req_o = 1'b1;
            if (rnd_ack_i) begin
               ack_a = 1'b1;
               st_d  = StGetB;
            end
         end
         StGetB: begin
            rnd_req_o = 1'b1;
            if (rnd_ack_i) begin
               ack_b = 1'b1;
               st_d  = StGetZ;
            end
         end
         StGetZ: begin
            rnd_req_o = 1'b1;
            if (rnd_ack_i) begin
               z_d    = rnd_i;
               hold_d = '0;
               st_d   = StShare;
            end
         end
         StShare: begin
            // Counter steps on the exit cycle too, so it leaves at HoldCycles and never wraps.
            hold_d = hold_q + 1'b1;
            if (hold_q == CntW'(HoldCycles - 1)) begin
               st_d = StPresent;
            end
         end
         StPresent: begin
            out_valid_o = 1'b1;
            if (out_ready_i) begin
               wipe = 1'b1;
               z_d  = '0;
               st_d = StIdle;
            end
         end
         default: begin
            // Unreachable encodings recover to a wiped idle.
            wipe   = 1'b1;
            z_d    = '0;
            hold_d = '0;
            st_d   = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         st_q   <= StIdle;
         hold_q <= '0;
         z_q    <= '0;
      end else begin
         st_q   <= st_d;
         hold_q <= hold_d;
         z_q    <= z_d;
      end
   end

   prim_dom_share_split #(
      .DW (DW)
   ) u_split_a (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .load_i   (load),
      .plain_i  (a_i),
      .ack_i    (ack_a),
      .rnd_i    (rnd_i),
      .clear_i  (wipe),
      .share0_o (a0_o),
      .share1_o (a1_o)
   );

   prim_dom_share_split #(
      .DW (DW)
   ) u_split_b (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .load_i   (load),
      .plain_i  (b_i),
      .ack_i    (ack_b),
      .rnd_i    (rnd_i),
      .clear_i  (wipe),
      .share0_o (b0_o),
      .share1_o (b1_o)
   );

   assign c0_o = z_q;
   assign c1_o = z_q;

endmodule
